// File: rtl/arb_pkg.sv
// Shared types and mode constants for the N-requester arbiter.
package arb_pkg;

    typedef enum logic [0:0] {ARB_IDLE, ARB_GRANT} arb_state_t;

    localparam bit ARB_MODE_FIXED = 1'b0;
    localparam bit ARB_MODE_RR    = 1'b1;

endpackage

// File: rtl/arb_rr_n_if.sv
// Request/grant bundle between N bus masters and the arbiter.
interface arb_rr_n_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic             gnt_valid;
    logic [ID_W-1:0]  gnt_id;

    modport master (output req, input gnt, gnt_valid, gnt_id);
    modport slave  (input req, output gnt, gnt_valid, gnt_id);
endinterface

// File: rtl/arb_pick.sv
// Combinational picker: first set request at or after a start index, wrapping.
module arb_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         i_req,
    input  logic [$clog2(N_REQ)-1:0] i_start,
    output logic [$clog2(N_REQ)-1:0] o_idx,
    output logic                     o_found
);
    localparam int ID_W = $clog2(N_REQ);
    localparam int DW   = $clog2(2 * N_REQ);

    logic [2*N_REQ-1:0] w_dbl;
    logic [DW-1:0]      w_pos;

    // Doubling the vector turns the wrap-around scan into a straight scan.
    assign w_dbl = {i_req, i_req};

    always_comb begin
        w_pos   = '0;
        o_idx   = '0;
        o_found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            w_pos = DW'(i_start) + DW'(i);
            if (!o_found && w_dbl[w_pos]) begin
                o_found = 1'b1;
                o_idx   = (w_pos >= DW'(N_REQ)) ? ID_W'(w_pos - DW'(N_REQ)) : ID_W'(w_pos);
            end
        end
    end
endmodule

// File: rtl/arb_rr_n.sv
// N-requester arbiter: round-robin or fixed priority, optional hold limit,
// registered one-hot grant with bubble-free handover.
module arb_rr_n
    import arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter bit RR_MODE  = ARB_MODE_RR,
    parameter int MAX_HOLD = 8,
    parameter int ID_W     = $clog2(N_REQ)
) (
    input  logic       clock,
    input  logic       reset,
    arb_rr_n_if.slave  bus
);
    localparam int HC_W      = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam int HOLD_LAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

    arb_state_t       r_state, w_state_nx;
    logic [ID_W-1:0]  r_own, w_own_nx;
    logic [ID_W-1:0]  r_last, w_last_nx;
    logic [HC_W-1:0]  r_hold, w_hold_nx;
    logic [ID_W-1:0]  w_start, w_win;
    logic [N_REQ-1:0] w_own_oh, w_mask, w_gnt;
    logic             w_found, w_own_req, w_exp;

    assign w_own_oh  = N_REQ'(1) << r_own;
    assign w_own_req = bus.req[r_own];
    assign w_exp     = (MAX_HOLD != 0) && (r_hold == HC_W'(HOLD_LAST));

    // While granted the owner is masked out, so a pick always means another requester.
    assign w_mask = (r_state == ARB_GRANT) ? (bus.req & ~w_own_oh) : bus.req;

    always_comb begin
        w_start = '0;
        if (RR_MODE == ARB_MODE_RR)
            w_start = (r_last == ID_W'(N_REQ - 1)) ? '0 : r_last + 1'b1;
    end

    arb_pick #(.N_REQ(N_REQ)) u_pick (
        .i_req   (w_mask),
        .i_start (w_start),
        .o_idx   (w_win),
        .o_found (w_found)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ARB_IDLE;
            r_own   <= '0;
            r_last  <= ID_W'(N_REQ - 1);
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_own   <= w_own_nx;
            r_last  <= w_last_nx;
            r_hold  <= w_hold_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_own_nx   = r_own;
        w_last_nx  = r_last;
        w_hold_nx  = r_hold;
        case (r_state)
            ARB_IDLE: begin
                if (w_found) begin
                    w_state_nx = ARB_GRANT;
                    w_own_nx   = w_win;
                    w_last_nx  = w_win;
                    w_hold_nx  = '0;
                end
            end
            ARB_GRANT: begin
                if (w_own_req && !w_exp) begin
                    w_hold_nx = r_hold + 1'b1;
                end else if (w_found) begin
                    w_own_nx  = w_win;
                    w_last_nx = w_win;
                    w_hold_nx = '0;
                end else if (w_own_req) begin
                    // Expired with nobody else waiting: fresh tenure, grant stays up.
                    w_hold_nx = '0;
                end else begin
                    w_state_nx = ARB_IDLE;
                    w_hold_nx  = '0;
                end
            end
            default: w_state_nx = ARB_IDLE;
        endcase
    end

    assign w_gnt         = (r_state == ARB_GRANT) ? w_own_oh : '0;
    assign bus.gnt       = w_gnt;
    assign bus.gnt_valid = (r_state == ARB_GRANT);
    assign bus.gnt_id    = (r_state == ARB_GRANT) ? r_own : '0;

    a_onehot: assert property (@(posedge clock) disable iff (reset)
        $onehot0(w_gnt));

    a_rise_needs_req: assert property (@(posedge clock) disable iff (reset)
        ((w_gnt & ~$past(w_gnt)) & ~$past(bus.req)) == '0);

    a_hold_limit: assert property (@(posedge clock) disable iff (reset)
        (r_state == ARB_GRANT && w_exp && (|(bus.req & ~w_gnt))) |=> (w_gnt != $past(w_gnt)));
endmodule

// File: tb/tb_arb_rr_n.sv
// Bench for arb_rr_n: directed table, hand sequences and random run against a reference model.
module tb_arb_rr_n;
    import arb_pkg::*;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] gnt;
    } vec_t;

    typedef struct {
        int own;
        int cnt;
        int last;
    } mst_t;

    logic clk;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    vec_t       tbl [29];
    mst_t       ms  [4];
    int         ns  [4];
    bit         rrs [4];
    int         mhs [4];
    logic [4:0] rq  [4];
    logic [4:0] cg  [4];
    int         waitc [5];
    logic [3:0] r4;
    logic [4:0] eg;
    bit         rr;
    int         wmax;

    arb_rr_n_if #(.N_REQ(4)) if_a ();
    arb_rr_n_if #(.N_REQ(4)) if_b ();
    arb_rr_n_if #(.N_REQ(4)) if_c ();
    arb_rr_n_if #(.N_REQ(5)) if_d ();

    arb_rr_n #(.N_REQ(4), .RR_MODE(ARB_MODE_RR),    .MAX_HOLD(3)) u_a (.clock(clk), .reset(rst), .bus(if_a));
    arb_rr_n #(.N_REQ(4), .RR_MODE(ARB_MODE_RR),    .MAX_HOLD(0)) u_b (.clock(clk), .reset(rst), .bus(if_b));
    arb_rr_n #(.N_REQ(4), .RR_MODE(ARB_MODE_FIXED), .MAX_HOLD(8)) u_c (.clock(clk), .reset(rst), .bus(if_c));
    arb_rr_n #(.N_REQ(5), .RR_MODE(ARB_MODE_RR),    .MAX_HOLD(4)) u_d (.clock(clk), .reset(rst), .bus(if_d));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [4:0] g, input logic v,
                         input logic [2:0] id, input logic [4:0] exp_g);
        logic [2:0] eid;
        logic       ev;
        eid = '0;
        for (int i = 0; i < 5; i++) if (exp_g[i]) eid = 3'(i);
        ev = |exp_g;
        n_vec++;
        if (g !== exp_g || v !== ev || id !== eid) begin
            n_err++;
            $display("FAIL %s @%0t: got gnt=%b valid=%b id=%0d, want gnt=%b valid=%b id=%0d",
                     nm, $time, g, v, id, exp_g, ev, eid);
        end
    endtask

    // Reference model: ownership tracked as an index (-1 idle) and a count of grant cycles in the tenure.
    function automatic int pick(int unsigned mask, int n, bit rrm, int last);
        int start;
        start = rrm ? (last + 1) % n : 0;
        for (int k = 0; k < n; k++)
            if (((mask >> ((start + k) % n)) & 1) != 0) return (start + k) % n;
        return -1;
    endfunction

    function automatic mst_t mstep(mst_t s, int unsigned req, int n, bit rrm, int mh, bit rs);
        mst_t t;
        int   w;
        bit   mine;
        t = s;
        if (rs) begin
            t.own = -1; t.cnt = 0; t.last = n - 1;
            return t;
        end
        if (s.own < 0) begin
            w = pick(req, n, rrm, s.last);
            if (w >= 0) begin t.own = w; t.cnt = 1; t.last = w; end
        end else begin
            mine = ((req >> s.own) & 1) != 0;
            if (mine && (mh == 0 || s.cnt < mh)) begin
                t.cnt = s.cnt + 1;
            end else begin
                w = pick(req & ~(32'd1 << s.own), n, rrm, s.last);
                if (w >= 0)    begin t.own = w; t.cnt = 1; t.last = w; end
                else if (mine) t.cnt = 1;
                else           begin t.own = -1; t.cnt = 0; end
            end
        end
        return t;
    endfunction

    function automatic logic [4:0] mgnt(mst_t s);
        return (s.own < 0) ? 5'b0 : (5'b00001 << s.own);
    endfunction

    initial begin
        tbl = '{
            '{1'b1, 4'b1111, 4'b0000}, '{1'b1, 4'b1111, 4'b0000}, '{1'b1, 4'b1111, 4'b0000},
            '{1'b0, 4'b1111, 4'b0001}, '{1'b0, 4'b1111, 4'b0001}, '{1'b0, 4'b1111, 4'b0001},
            '{1'b0, 4'b1111, 4'b0010}, '{1'b0, 4'b0011, 4'b0010}, '{1'b0, 4'b0011, 4'b0010},
            '{1'b0, 4'b0011, 4'b0001}, '{1'b0, 4'b0011, 4'b0001}, '{1'b0, 4'b0011, 4'b0001},
            '{1'b0, 4'b0011, 4'b0010}, '{1'b0, 4'b0001, 4'b0001}, '{1'b0, 4'b0001, 4'b0001},
            '{1'b0, 4'b0001, 4'b0001}, '{1'b0, 4'b0001, 4'b0001}, '{1'b0, 4'b0001, 4'b0001},
            '{1'b0, 4'b0100, 4'b0100}, '{1'b0, 4'b0100, 4'b0100}, '{1'b0, 4'b0100, 4'b0100},
            '{1'b0, 4'b0100, 4'b0100}, '{1'b0, 4'b0000, 4'b0000}, '{1'b0, 4'b0000, 4'b0000},
            '{1'b0, 4'b0010, 4'b0010}, '{1'b0, 4'b0011, 4'b0010}, '{1'b1, 4'b1010, 4'b0000},
            '{1'b0, 4'b0110, 4'b0010}, '{1'b0, 4'b0000, 4'b0000}
        };
        rst = 1'b1;
        if_a.req = '0; if_b.req = '0; if_c.req = '0; if_d.req = '0;

        // Table: reset, hold limit, re-grant without bubble, release, mid-tenure reset.
        for (int k = 0; k < 29; k++) begin
            rst      = tbl[k].rst;
            if_a.req = tbl[k].req;
            tick();
            check($sformatf("tbl%0d", k), {1'b0, if_a.gnt}, if_a.gnt_valid,
                  {1'b0, if_a.gnt_id}, {1'b0, tbl[k].gnt});
        end
        if_a.req = '0;

        rst = 1'b1; tick(); rst = 1'b0;
        if_b.req = 4'b1111; tick();
        check("rr_first", {1'b0, if_b.gnt}, if_b.gnt_valid, {1'b0, if_b.gnt_id}, 5'b00001);
        tick();
        check("rr_stay0", {1'b0, if_b.gnt}, if_b.gnt_valid, {1'b0, if_b.gnt_id}, 5'b00001);
        for (int k = 1; k <= 4; k++) begin
            r4 = 4'b1111;
            r4[(k - 1) % 4] = 1'b0;
            eg = 5'b00001 << (k % 4);
            if_b.req = r4; tick();
            check($sformatf("rr_handover%0d", k), {1'b0, if_b.gnt}, if_b.gnt_valid, {1'b0, if_b.gnt_id}, eg);
            if_b.req = 4'b1111; tick();
            check($sformatf("rr_stay%0d", k), {1'b0, if_b.gnt}, if_b.gnt_valid, {1'b0, if_b.gnt_id}, eg);
        end
        if_b.req = '0;

        rst = 1'b1; tick(); rst = 1'b0;
        if_c.req = 4'b1010; tick();
        check("fix_low", {1'b0, if_c.gnt}, if_c.gnt_valid, {1'b0, if_c.gnt_id}, 5'b00010);
        if_c.req = 4'b1000; tick();
        check("fix_next", {1'b0, if_c.gnt}, if_c.gnt_valid, {1'b0, if_c.gnt_id}, 5'b01000);
        if_c.req = 4'b1010; tick();
        check("fix_nopreempt", {1'b0, if_c.gnt}, if_c.gnt_valid, {1'b0, if_c.gnt_id}, 5'b01000);
        if_c.req = 4'b0000; tick();
        check("fix_idle", {1'b0, if_c.gnt}, if_c.gnt_valid, {1'b0, if_c.gnt_id}, 5'b00000);
        if_c.req = 4'b1111; tick();
        check("fix_all", {1'b0, if_c.gnt}, if_c.gnt_valid, {1'b0, if_c.gnt_id}, 5'b00001);
        if_c.req = '0;

        // Random run: requesters hold req until granted; occasional reset.
        ns  = '{4, 4, 4, 5};
        rrs = '{1'b1, 1'b1, 1'b0, 1'b1};
        mhs = '{3, 0, 8, 4};
        rst = 1'b1; tick(); rst = 1'b0;
        for (int j = 0; j < 4; j++) begin
            ms[j] = '{-1, 0, ns[j] - 1};
            rq[j] = '0;
        end
        for (int i = 0; i < 5; i++) waitc[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            cg[0] = {1'b0, if_a.gnt}; cg[1] = {1'b0, if_b.gnt};
            cg[2] = {1'b0, if_c.gnt}; cg[3] = if_d.gnt;
            for (int j = 0; j < 4; j++)
                for (int i = 0; i < ns[j]; i++) begin
                    if (rq[j][i] && !cg[j][i]) rq[j][i] = 1'b1;
                    else if (cg[j][i])         rq[j][i] = ($urandom_range(0, 3) != 0);
                    else                       rq[j][i] = ($urandom_range(0, 2) == 0);
                end
            rr  = ($urandom_range(0, 399) == 0);
            rst = rr;
            if_a.req = rq[0][3:0]; if_b.req = rq[1][3:0];
            if_c.req = rq[2][3:0]; if_d.req = rq[3];
            for (int j = 0; j < 4; j++) ms[j] = mstep(ms[j], 32'(rq[j]), ns[j], rrs[j], mhs[j], rr);
            tick();
            check("rnd_a", {1'b0, if_a.gnt}, if_a.gnt_valid, {1'b0, if_a.gnt_id}, mgnt(ms[0]));
            check("rnd_b", {1'b0, if_b.gnt}, if_b.gnt_valid, {1'b0, if_b.gnt_id}, mgnt(ms[1]));
            check("rnd_c", {1'b0, if_c.gnt}, if_c.gnt_valid, {1'b0, if_c.gnt_id}, mgnt(ms[2]));
            check("rnd_d", if_d.gnt, if_d.gnt_valid, if_d.gnt_id, mgnt(ms[3]));
            wmax = 0;
            for (int i = 0; i < 5; i++) begin
                if (!rr && rq[3][i] && !if_d.gnt[i]) waitc[i]++;
                else                                  waitc[i] = 0;
                if (waitc[i] > wmax) wmax = waitc[i];
            end
            n_vec++;
            if (wmax > 20) begin
                n_err++;
                $display("FAIL starve_d @%0t: waited %0d cycles, limit 20", $time, wmax);
            end
        end
        rst = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/arb_rr_n.md
# arb_rr_n

Parametrised N-requester bus arbiter, the successor to the two-requester grant FSM. It arbitrates between N_REQ request lines in either round-robin or fixed-priority mode. An optional hold limit prevents one requester from monopolising the resource, and ownership hands over directly to the next requester without an idle bubble. It sits between N bus masters and a single shared slave port; grants are registered and one-hot.

## Interface

- N_REQ, 4: number of requesters; legal range 2..32.
- RR_MODE, 1: 1 selects round-robin, 0 selects fixed priority (lowest index wins).
- MAX_HOLD, 8: maximum consecutive grant cycles per tenure; 0 means unlimited.
- ID_W, $clog2(N_REQ): width of gnt_id; derived, not to be overridden.

Ports:

- clock  in  1  single clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  N_REQ  request vector; bit i is held high while master i wants the resource.
- gnt  out  N_REQ  one-hot grant vector; all-zero when idle.
- gnt_valid  out  1  high when any grant is active (OR of gnt).
- gnt_id  out  ID_W  index of the granted requester; 0 when idle.

## Operation

- The FSM has two states.
  - IDLE: no owner.
  - GRANT: owner register `own` is valid.
- Winner selection is done by the picker.
  - RR_MODE=1: scan req starting at (last + 1) mod N_REQ, where `last` is the most recent owner; the first set bit wins.
  - RR_MODE=0: the lowest set index wins; `last` is ignored.
- Transitions at each clock edge:
  - IDLE, req==0: stay in IDLE.
  - IDLE, req!=0: go to GRANT. own=winner(req), hold_cnt=0, last=winner.
  - GRANT, req[own]=1 and not expired: stay; hold_cnt+1.
  - GRANT, req[own]=0:
    - if req!=0: hand over to winner(req) with hold_cnt=0.
    - if req==0: go to IDLE.
  - GRANT, expired, other requests pending: hand over to winner(req & ~onehot(own)) with hold_cnt=0.
  - GRANT, expired, only own requesting: re-grant own with hold_cnt=0; no bubble.
- "Expired" means MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1.
- Widths:
  - hold_cnt is $clog2(MAX_HOLD+1) bits, minimum 1.
  - Index arithmetic wraps modulo N_REQ; no out-of-range index is ever produced.
- Outputs are decoded from registered state only.
  - gnt = onehot(own) in GRANT, 0 in IDLE.
  - gnt_id = own in GRANT, 0 in IDLE.
  - There is no combinational path from req to gnt.
- Reset values: state=IDLE, gnt=0, gnt_valid=0, gnt_id=0, hold_cnt=0, last=N_REQ-1. After reset, index 0 has first round-robin priority.
- Reset has priority over all transitions, including mid-tenure. The grant drops on the cycle after the reset edge.
- Embedded assertions, disabled while reset is high:
  - gnt is one-hot-or-zero.
  - A gnt bit rises only if the matching req bit was high in the previous cycle.
  - With MAX_HOLD!=0, no gnt bit stays high for more than MAX_HOLD consecutive cycles while other req bits are high.

## Timing

- Grant latency is 1 cycle: req sampled high at edge k gives gnt high after edge k.
- Release: req[own] low at edge k gives gnt[own] low after edge k. If handing over, the new gnt bit rises in the same cycle, so there is no gap.
- Forced handover happens at the MAX_HOLD-th edge of a tenure. The owner therefore sees exactly MAX_HOLD grant cycles.
- Requests that rise and fall between edges are not seen. A requester must hold req until granted.
- When the owner drops req in the same cycle another requester raises it, the handover occurs without an idle cycle.
- req changes while reset is high are ignored.

## Structure

- Package arb_pkg holds:
  - typedef enum logic [0:0] {ARB_IDLE, ARB_GRANT} arb_state_t;
  - mode constants ARB_MODE_FIXED=0 and ARB_MODE_RR=1.
- Sub-module arb_pick: purely combinational.
  - Parameters: N_REQ.
  - Inputs: req, start index.
  - Outputs: winner index, found flag.
  - Rotating priority is implemented via a doubled-vector scan.
  - Fixed mode drives start=0.
- Top level contains the FSM, own, last and hold_cnt registers, output decode and assertions.

## Test plan

- Reset and idle: hold reset 3 cycles with req=4'b1111 → gnt=0, gnt_id=0 during reset. The first grant after reset is index 0 when RR_MODE=1.
- Round-robin fairness: N_REQ=4, MAX_HOLD=0, req=4'b1111, each owner drops req for one cycle after 2 grant cycles → grant order 0,1,2,3,0 with no idle cycle between owners.
- Fixed priority: RR_MODE=0, req=4'b1010, then req[1] dropped → gnt=4'b0010 first, then gnt=4'b1000 on the next cycle.
- Hold limit: MAX_HOLD=3, req=4'b0011 held constant → gnt alternates 0001 ×3 cycles, 0010 ×3 cycles. With only req[0] high, gnt=0001 stays continuous and hold_cnt restarts every 3 cycles.
- Release to idle and mid-tenure reset: single req[2] pulse of 4 cycles → gnt[2] high for 4 cycles, then 0. Reset asserted during a grant → gnt=0 the cycle after the reset edge, and last returns to 3.
- Random stress: 10k cycles of random req with N_REQ=5, MAX_HOLD=4 → no assertion fires, and every requester holding req continuously is granted within N_REQ·MAX_HOLD cycles.
